// File: rtl/demux_pkg.sv
// Shared lane constants, lane index type and the round-robin pick helper
// used by the demux lane deserializer.
package demux_pkg;

  localparam int unsigned LANES     = 4;
  localparam int unsigned OVF_CNT_W = 8;

  typedef logic [1:0] lane_t;

  // First requesting lane at or after ptr, wrapping; returns ptr when nothing requests.
  function automatic lane_t rr_pick(input logic [LANES-1:0] req, input lane_t ptr);
    lane_t idx;
    rr_pick = ptr;
    for (int k = LANES - 1; k >= 0; k--) begin
      idx = ptr + lane_t'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/demux_lane_deser4_if.sv
// Valid/ready word stream carrying assembled words and their source lane.
interface demux_lane_deser4_if #(
  parameter int unsigned WIDTH = 8
);
  import demux_pkg::*;

  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  lane_t            out_lane;

  modport master (output out_vld, output out_data, output out_lane, input out_rdy);
  modport slave  (input out_vld, input out_data, input out_lane, output out_rdy);

endinterface

// File: rtl/lane_shifter.sv
// One demux lane: shift register, bit counter and a single-entry holding register.
// done pulses on the cycle the last bit of a word is shifted in.
module lane_shifter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             din,
  input  logic             drain,
  output logic [WIDTH-1:0] hold,
  output logic             full,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full_q, full_d;

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    full_d = full_q;
    done   = 1'b0;
    if (drain) full_d = 1'b0;
    if (shift) begin
      sr_d = {sr_q[WIDTH-2:0], din};
      if (cnt_q == CntW'(WIDTH - 1)) begin
        cnt_d = '0;
        done  = 1'b1;
        // A word landing on an undrained full slot is dropped; hold keeps the old word.
        if (!full_q || drain) begin
          hold_d = sr_d;
          full_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

  assign hold = hold_q;
  assign full = full_q;

endmodule

// File: rtl/demux_lane_deser4.sv
// Four-lane deserializer behind a 1-to-4 demux with a round-robin merged output stream.
// Optional macro DESER_OVF_CNT_EN adds per-lane saturating drop counters on ovf_cnt.
module demux_lane_deser4
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_vld,
  input  lane_t                 sel,
  input  logic                  y0,
  input  logic                  y1,
  input  logic                  y2,
  input  logic                  y3,
  demux_lane_deser4_if.master   stream,
  output logic [LANES-1:0]      ovf,
  input  logic                  ovf_clr
`ifdef DESER_OVF_CNT_EN
  ,
  output logic [LANES*OVF_CNT_W-1:0] ovf_cnt
`endif
);

  logic [LANES-1:0] y, full, done, drain, drop;
  logic [WIDTH-1:0] hold [LANES];
  lane_t            win;
  logic             free, grant;

  lane_t            rr_ptr_q, rr_ptr_d;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  lane_t            out_lane_q, out_lane_d;
  logic [LANES-1:0] ovf_q, ovf_d;

  assign y = {y3, y2, y1, y0};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_shifter #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .shift (bit_vld && (sel == lane_t'(i))),
      .din   (y[i]),
      .drain (drain[i]),
      .hold  (hold[i]),
      .full  (full[i]),
      .done  (done[i])
    );
  end

  assign win   = rr_pick(full, rr_ptr_q);
  assign free  = !out_vld_q || stream.out_rdy;
  assign grant = free && (|full);
  assign drain = grant ? (LANES'(1) << win) : '0;
  assign drop  = done & full & ~drain;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_lane_d = out_lane_q;
    rr_ptr_d   = rr_ptr_q;
    if (free) out_vld_d = grant;
    if (grant) begin
      out_data_d = hold[win];
      out_lane_d = win;
      rr_ptr_d   = win + lane_t'(1);
    end
    // A new overflow wins over a simultaneous clear on its own lane.
    ovf_d = (ovf_clr ? '0 : ovf_q) | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_lane_q <= '0;
      rr_ptr_q   <= '0;
      ovf_q      <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_lane_q <= out_lane_d;
      rr_ptr_q   <= rr_ptr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign stream.out_vld  = out_vld_q;
  assign stream.out_data = out_data_q;
  assign stream.out_lane = out_lane_q;
  assign ovf             = ovf_q;

`ifdef DESER_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] cnt_q [LANES];
  logic [OVF_CNT_W-1:0] cnt_d [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      cnt_d[i] = ovf_clr ? '0 : cnt_q[i];
      if (drop[i] && (cnt_d[i] != '1)) cnt_d[i] = cnt_d[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (rst) cnt_q[i] <= '0;
      else     cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    ovf_cnt = '0;
    for (int i = 0; i < LANES; i++) ovf_cnt[i*OVF_CNT_W +: OVF_CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: doc/demux_lane_deser4.md
# demux_lane_deser4

Collects the four 1-bit lanes of a 1-to-4 demultiplexer (`y0..y3`, routed by `sel`) into per-lane `WIDTH`-bit words. It sits directly downstream of `demux1to4`. Completed words are merged onto a single valid/ready output stream using round-robin arbitration. Lost words are flagged per lane.

## Interface
Parameters:
- `WIDTH`, default 8: bits per assembled word (must be ≥ 2).

Ports:
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `bit_vld`, in, 1: a demux output is valid this cycle.
- `sel`, in, 2: lane index that the demux drove this cycle.
- `y0`, `y1`, `y2`, `y3`, in, 1 each: demux outputs. The sampled bit is `y[sel]`.
- `out_vld`, out, 1: an output word is present.
- `out_rdy`, in, 1: the consumer accepts the word.
- `out_data`, out, `WIDTH`: the assembled word.
- `out_lane`, out, 2: the lane the word came from.
- `ovf`, out, 4: sticky per-lane overflow flags.
- `ovf_clr`, in, 1: clears all `ovf` bits.

## Operation
- Per lane `i`, there are three pieces of state:
  - a shift register `sr[i]` (`WIDTH` bits);
  - a bit counter `cnt[i]` (0..`WIDTH-1`);
  - a holding register `hold[i]` with a `full[i]` flag.
- Shifting: when `bit_vld` is high, `sr[sel]` becomes `{sr[sel][WIDTH-2:0], y[sel]}`. The first bit received ends up as the MSB. Other lanes are untouched.
- Word completion: a word completes when `bit_vld` is high and `cnt[sel]` equals `WIDTH-1`.
  - The full word `{sr[WIDTH-2:0], y[sel]}` is loaded into `hold[sel]` and `full[sel]` is set.
  - `cnt[sel]` wraps to 0.
- Overflow: if the word completes while `full[sel]` is set and that lane is not being drained this cycle:
  - the new word is dropped and `hold` keeps the old word;
  - `ovf[sel]` is set;
  - `cnt` still wraps.
- Arbiter: round-robin over lanes with `full` set, starting at `rr_ptr`.
  - A grant happens when the output register is free, that is `!out_vld || out_rdy`.
  - On a grant, the winning `hold` moves to `out_data`/`out_lane`, `out_vld` is set, the winner's `full` clears, and `rr_ptr` becomes winner+1 (mod 4).
  - With no `full` lanes, the free output register drops `out_vld` and `rr_ptr` is unchanged.
- Simultaneous drain and completion on the same lane: the drain takes the old word and `hold` loads the new word, with `full` remaining set. This is not an overflow.
- `ovf_clr` and a new overflow in the same cycle: the set wins for that lane, and the other lanes clear.
- Output stability: `out_data` and `out_lane` are stable while `out_vld && !out_rdy`.

## Timing
- Reset values: all of the following are 0 after reset.
  - `out_vld` = 0, `out_data` = 0, `out_lane` = 0, `ovf` = 0.
  - All `sr`, `cnt` and `full` = 0.
  - `rr_ptr` = 0.
- Latency: if the last bit is sampled at edge N, `full` is set after edge N, and `out_vld` rises after edge N+1 when the output register is free.
- Throughput: one word per cycle when `out_rdy` is held high.
- Reset mid-word: any partial words are discarded and lane bit counts restart at 0.
- `bit_vld` low: there is no state change in the lanes. The arbiter keeps running.

## Configuration
- Macro `DESER_OVF_CNT_EN`.
- Defined: adds output `ovf_cnt`, 32 bits wide, made of four 8-bit saturating drop counters (lane `i` in bits `[8i+7:8i]`).
  - A counter increments on every dropped word for its lane and saturates at 255.
  - `ovf_clr` zeroes all four counters.
  - All counters reset to 0.
- Undefined: there is no `ovf_cnt` port and no counter logic. Only the sticky `ovf` flags remain.

## Structure
- Shared package `demux_pkg`:
  - `LANES` = 4;
  - `lane_t` (2-bit lane index);
  - the counter width constant `OVF_CNT_W` = 8.
- Sub-module `lane_shifter`: one lane's `sr`/`cnt`/`hold`/`full` state, with a completion pulse and a drain input. It is instantiated 4 times. The arbiter and output register stay in the top level.

## Test plan
- Reset, then send 8 bits 1,0,1,0,0,1,0,1 on `sel`=2 with `out_rdy`=1: `out_vld` pulses once with `out_data`=8'hA5 and `out_lane`=2, one cycle after the holding load.
- Interleave 8 bits each of lane 0 (8'h11) and lane 3 (8'hF0), alternating `sel` every cycle: two words are output, with each lane's bits uncorrupted.
- Complete words on lanes 0,1,2,3 together-pending with `out_rdy`=0, then raise `out_rdy`: the words emerge in order 0,1,2,3, and then `rr_ptr`=0.
- With `out_rdy`=0, complete two more words on lane 1 (after one word is already in `out` and one in `hold`): `ovf[1]`=1 and the held word is the first one. With `DESER_OVF_CNT_EN`, `ovf_cnt[15:8]`=1. Pulse `ovf_clr`: all are cleared.
- Hold `out_rdy`=0 with lane 1 in the output register and lane 2 in `hold`: `out_data`/`out_lane` stay constant. When `out_rdy` rises while lane 2 completes another word in the same cycle: lane 2's old word is output, the new word is held, and there is no `ovf`.
- Assert `rst` after 5 of 8 bits on lane 0, then send 8 bits 8'h3C: exactly one word 8'h3C is output, and `ovf` = 0.
